atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
Parametrised ATM session controller: the next generation of the team's ATM transaction FSM. It takes one card session from insertion to ejection: PIN check with a configurable retry limit, operation menu, balance update, and a "another service?" loop. Compared with the current FSM it adds:
- an internal inactivity timer (no external timer block);
- a per-session withdrawal limit;
- deposit overflow protection;
- encoded error reporting;
- card retention after the PIN retry limit is reached.

It sits between the keypad/card-reader front end and the account store. It reads the balance once at card insertion and writes back through a one-cycle strobe.

Parameters:
BAL_W, 20, width of balance and amount.
TIMEOUT_CYC, 1000, idle cycles allowed in any waiting state before forced eject (must be >=2).
PIN_TRIES, 3, wrong PINs allowed before the card is retained (1..7).
WD_LIMIT, 5000, maximum cumulative withdrawal per session.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
card_in  in  1  one-cycle pulse: card inserted; sampled only in IDLE
acct_balance  in  BAL_W  account balance; sampled on the card_in cycle
pin_valid  in  1  PIN entry strobe
pin_ok  in  1  PIN correct; qualified by pin_valid
op_valid  in  1  operation request strobe
op  in  2  00 withdraw, 01 deposit, 10 inquiry, 11 exit
amount  in  BAL_W  operand; sampled with op_valid
svc_valid  in  1  answer strobe for "another service?"
svc_more  in  1  1 = another service, 0 = finish; qualified by svc_valid
balance  out  BAL_W  session balance register
balance_we  out  1  one-cycle write-back strobe; balance holds the new value
op_done  out  1  one-cycle pulse: operation completed successfully
error  out  1  one-cycle pulse: operation or session error
err_code  out  3  0 none, 1 wrong PIN, 2 insufficient funds, 3 over limit, 4 deposit overflow, 5 zero amount, 6 timeout; holds until the next error or IDLE
card_out  out  1  one-cycle pulse: card ejected
card_retained  out  1  one-cycle pulse: card kept
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - state = IDLE;
  - all outputs 0;
  - balance = 0, err_code = 0;
  - internal registers tries_used = 0, wd_sum = 0, timer = 0.
- Reset mid-session aborts with no write-back and no card_out pulse.
- States: IDLE, PIN, MENU, EXEC, MORE, EJECT, RETAIN.
- IDLE:
  - card_in -> PIN; load balance = acct_balance; clear tries_used, wd_sum, err_code, timer.
  - pin_valid, op_valid and svc_valid are ignored.
- PIN, on pin_valid:
  - pin_ok = 1 -> MENU.
  - pin_ok = 0 -> error pulse, err_code = 1, tries_used += 1.
  - If tries_used reaches PIN_TRIES -> RETAIN; otherwise stay in PIN.
- MENU, on op_valid:
  - latch op and amount;
  - op = 11 -> EJECT; any other op -> EXEC.
- EXEC (exactly one cycle), checks in priority order:
  - withdraw or deposit with amount = 0 -> error, code 5.
  - withdraw:
    - amount > balance -> code 2;
    - else wd_sum + amount > WD_LIMIT -> code 3 (compare at BAL_W+1 bits);
    - else balance -= amount, wd_sum += amount.
  - deposit: balance + amount >= 2^BAL_W -> code 4 (carry bit of a BAL_W+1 add); else balance += amount.
  - inquiry: no change.
  - On success: op_done pulses in the EXEC cycle. balance_we pulses in the cycle after EXEC, with balance already updated (withdraw/deposit only).
  - On error: error pulses, balance and wd_sum unchanged.
  - EXEC -> MORE in both cases.
- MORE, on svc_valid:
  - svc_more = 1 -> MENU;
  - svc_more = 0 -> EJECT.
- EJECT: card_out pulse for one cycle -> IDLE.
- RETAIN: card_retained pulse for one cycle -> IDLE.
- Inactivity timer:
  - Counts in PIN, MENU and MORE.
  - Clears on state entry and on any accepted strobe.
  - When timer = TIMEOUT_CYC-1 with no strobe that cycle -> error pulse, err_code = 6, go to EJECT.
  - If a strobe and the timeout coincide, the strobe wins.
- Strobes arriving in states that do not consume them are ignored. Only one strobe is consumed per cycle.
- Latency:
  - card_in to PIN: 1 cycle.
  - Accepted op to op_done: 1 cycle (MENU -> EXEC).
  - EXEC to balance_we: 1 cycle.

Test Plan:
1. card_in with acct_balance = 1000; PIN ok; withdraw 300; svc_more = 0 -> op_done; balance_we with balance = 700; card_out pulse; IDLE.
2. Three wrong PINs (PIN_TRIES = 3) -> error pulses with err_code = 1 on each; card_retained pulse after the third; no card_out; no balance_we.
3. Balance 1000, WD_LIMIT = 5000: withdraw 2000 -> err_code 2. Then deposit 9000 -> balance 10000. Withdraw 4000, then withdraw 1500 -> second gives err_code 3, balance stays 6000.
4. BAL_W = 20, balance 0xFFFF0: deposit 0x20 -> err_code 4, balance unchanged. Deposit 0xF -> balance 0xFFFFF.
5. TIMEOUT_CYC = 8: enter MENU and give no input -> after 8 cycles error pulse with err_code 6, then card_out. Repeat with op_valid exactly on the timeout cycle -> operation accepted, no timeout.
6. Reset asserted during EXEC -> all outputs 0 asynchronously. After release, state IDLE and pin_valid/op_valid are ignored until card_in.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// ---------------------------------------------------------------------------
// atm_session_ctrl
//   Runs one card session from insertion to ejection. It checks the PIN with a
//   retry limit, serves an operation menu (withdraw / deposit / inquiry / exit),
//   updates the session balance and asks whether another service is wanted.
//   An internal inactivity timer ejects the card if the customer stops
//   responding. The card is kept after too many wrong PINs.
//
// Parameters
//   BAL_W        width of balance and amount
//   TIMEOUT_CYC  idle cycles allowed in PIN / MENU / MORE (>= 2)
//   PIN_TRIES    wrong PINs allowed before the card is retained (1..7)
//   WD_LIMIT     maximum cumulative withdrawal per session
//
// Ports
//   clk, rst       clock, asynchronous active-low reset
//   card_in        card inserted pulse (IDLE only); acct_balance sampled with it
//   pin_valid      PIN entry strobe, pin_ok qualifies it
//   op_valid       operation strobe, op / amount sampled with it
//   svc_valid      "another service?" answer strobe, svc_more qualifies it
//   balance        session balance register
//   balance_we     one-cycle write-back strobe (balance already updated)
//   op_done        one-cycle pulse, operation completed successfully
//   error          one-cycle pulse, operation or session error
//   err_code       last error code, visible with the error pulse, held after it
//   card_out       one-cycle pulse, card ejected
//   card_retained  one-cycle pulse, card kept
//   busy           high in every state except IDLE
// ---------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter int BAL_W       = 20,
  parameter int TIMEOUT_CYC = 1000,
  parameter int PIN_TRIES   = 3,
  parameter int WD_LIMIT    = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic [BAL_W-1:0] acct_balance,
  input  logic             pin_valid,
  input  logic             pin_ok,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [BAL_W-1:0] amount,
  input  logic             svc_valid,
  input  logic             svc_more,
  output logic [BAL_W-1:0] balance,
  output logic             balance_we,
  output logic             op_done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic             card_out,
  output logic             card_retained,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_MENU,
    S_EXEC,
    S_MORE,
    S_EJECT,
    S_RETAIN
  } state_t;

  localparam int               TMR_W     = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       TRIES_MAX = 3'(PIN_TRIES);
  localparam logic [BAL_W:0]   WD_LIM    = (BAL_W + 1)'(WD_LIMIT);

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PIN   = 3'd1;
  localparam logic [2:0] E_FUNDS = 3'd2;
  localparam logic [2:0] E_LIMIT = 3'd3;
  localparam logic [2:0] E_OVFL  = 3'd4;
  localparam logic [2:0] E_ZERO  = 3'd5;
  localparam logic [2:0] E_TMO   = 3'd6;

  state_t             state_reg,      state_next;
  logic [BAL_W-1:0]   balance_reg,    balance_next;
  logic [BAL_W-1:0]   wd_sum_reg,     wd_sum_next;
  logic [2:0]         tries_reg,      tries_next;
  logic [TMR_W-1:0]   timer_reg,      timer_next;
  logic [2:0]         err_code_reg,   err_code_next;
  logic [1:0]         op_reg,         op_next;
  logic [BAL_W-1:0]   amount_reg,     amount_next;
  logic               balance_we_reg, balance_we_next;

  logic [2:0]         err_now;
  logic               strobe;
  logic               tmr_expired;
  logic [BAL_W:0]     dep_sum;
  logic [BAL_W:0]     wd_total;

  // Both sums are one bit wider so the carry / limit test cannot wrap.
  assign dep_sum     = {1'b0, balance_reg} + {1'b0, amount_reg};
  assign wd_total    = {1'b0, wd_sum_reg} + {1'b0, amount_reg};
  assign tmr_expired = (timer_reg == TMR_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      balance_reg    <= '0;
      wd_sum_reg     <= '0;
      tries_reg      <= '0;
      timer_reg      <= '0;
      err_code_reg   <= E_NONE;
      op_reg         <= '0;
      amount_reg     <= '0;
      balance_we_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      balance_reg    <= balance_next;
      wd_sum_reg     <= wd_sum_next;
      tries_reg      <= tries_next;
      timer_reg      <= timer_next;
      err_code_reg   <= err_code_next;
      op_reg         <= op_next;
      amount_reg     <= amount_next;
      balance_we_reg <= balance_we_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    balance_next    = balance_reg;
    wd_sum_next     = wd_sum_reg;
    tries_next      = tries_reg;
    timer_next      = timer_reg;
    err_code_next   = err_code_reg;
    op_next         = op_reg;
    amount_next     = amount_reg;
    balance_we_next = 1'b0;
    op_done         = 1'b0;
    error           = 1'b0;
    err_now         = E_NONE;
    strobe          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        err_code_next = E_NONE;
        if (card_in) begin
          state_next   = S_PIN;
          balance_next = acct_balance;
          tries_next   = '0;
          wd_sum_next  = '0;
        end
      end

      S_PIN: begin
        if (pin_valid) begin
          strobe = 1'b1;
          if (pin_ok) begin
            state_next = S_MENU;
          end else begin
            error      = 1'b1;
            err_now    = E_PIN;
            tries_next = tries_reg + 3'd1;
            if (tries_next == TRIES_MAX) state_next = S_RETAIN;
          end
        end else if (tmr_expired) begin
          error      = 1'b1;
          err_now    = E_TMO;
          state_next = S_EJECT;
        end
      end

      S_MENU: begin
        if (op_valid) begin
          strobe      = 1'b1;
          op_next     = op;
          amount_next = amount;
          state_next  = (op == 2'b11) ? S_EJECT : S_EXEC;
        end else if (tmr_expired) begin
          error      = 1'b1;
          err_now    = E_TMO;
          state_next = S_EJECT;
        end
      end

      S_EXEC: begin
        state_next = S_MORE;
        case (op_reg)
          2'b00: begin
            if (amount_reg == '0) begin
              error   = 1'b1;
              err_now = E_ZERO;
            end else if (amount_reg > balance_reg) begin
              error   = 1'b1;
              err_now = E_FUNDS;
            end else if (wd_total > WD_LIM) begin
              error   = 1'b1;
              err_now = E_LIMIT;
            end else begin
              op_done         = 1'b1;
              balance_next    = balance_reg - amount_reg;
              wd_sum_next     = wd_total[BAL_W-1:0];
              balance_we_next = 1'b1;
            end
          end
          2'b01: begin
            if (amount_reg == '0) begin
              error   = 1'b1;
              err_now = E_ZERO;
            end else if (dep_sum[BAL_W]) begin
              error   = 1'b1;
              err_now = E_OVFL;
            end else begin
              op_done         = 1'b1;
              balance_next    = dep_sum[BAL_W-1:0];
              balance_we_next = 1'b1;
            end
          end
          // Inquiry; exit never reaches EXEC.
          default: op_done = 1'b1;
        endcase
      end

      S_MORE: begin
        if (svc_valid) begin
          strobe     = 1'b1;
          state_next = svc_more ? S_MENU : S_EJECT;
        end else if (tmr_expired) begin
          error      = 1'b1;
          err_now    = E_TMO;
          state_next = S_EJECT;
        end
      end

      // The code is cleared on the way back to IDLE so IDLE always reads 0.
      S_EJECT: begin
        state_next    = S_IDLE;
        err_code_next = E_NONE;
      end

      S_RETAIN: begin
        state_next    = S_IDLE;
        err_code_next = E_NONE;
      end

      default: state_next = S_IDLE;
    endcase

    if (error) err_code_next = err_now;

    // Restart the idle count on any state change or consumed strobe.
    if ((state_next != state_reg) || strobe) begin
      timer_next = '0;
    end else if ((state_reg == S_PIN) || (state_reg == S_MENU) || (state_reg == S_MORE)) begin
      timer_next = timer_reg + TMR_W'(1);
    end else begin
      timer_next = '0;
    end
  end

  // Forward the fresh code so it is visible in the same cycle as the pulse.
  assign err_code      = error ? err_now : err_code_reg;
  assign balance       = balance_reg;
  assign balance_we    = balance_we_reg;
  assign card_out      = (state_reg == S_EJECT);
  assign card_retained = (state_reg == S_RETAIN);
  assign busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_atm_session_ctrl
//   Directed bench for atm_session_ctrl (BAL_W=20, TIMEOUT_CYC=8,
//   PIN_TRIES=3, WD_LIMIT=5000). Inputs change 1 time unit after the rising
//   edge, outputs are sampled 1 unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in;
  logic [19:0] acct_balance;
  logic        pin_valid;
  logic        pin_ok;
  logic        op_valid;
  logic [1:0]  op;
  logic [19:0] amount;
  logic        svc_valid;
  logic        svc_more;
  logic [19:0] balance;
  logic        balance_we;
  logic        op_done;
  logic        error;
  logic [2:0]  err_code;
  logic        card_out;
  logic        card_retained;
  logic        busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Values captured by the transaction tasks.
  logic        s_error, s_done, s_we;
  logic [2:0]  s_code;
  logic [19:0] s_bal;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .BAL_W       (20),
    .TIMEOUT_CYC (8),
    .PIN_TRIES   (3),
    .WD_LIMIT    (5000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .card_in       (card_in),
    .acct_balance  (acct_balance),
    .pin_valid     (pin_valid),
    .pin_ok        (pin_ok),
    .op_valid      (op_valid),
    .op            (op),
    .amount        (amount),
    .svc_valid     (svc_valid),
    .svc_more      (svc_more),
    .balance       (balance),
    .balance_we    (balance_we),
    .op_done       (op_done),
    .error         (error),
    .err_code      (err_code),
    .card_out      (card_out),
    .card_retained (card_retained),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first PIN cycle.
  task automatic start_session(input logic [19:0] bal);
    card_in      = 1'b1;
    acct_balance = bal;
    tick();
    card_in = 1'b0;
    #1;
    $display("txn card_in bal=%0d busy=%0b balance=%0d", bal, busy, balance);
  endtask

  task automatic do_pin(input logic ok);
    pin_valid = 1'b1;
    pin_ok    = ok;
    #1;
    s_error = error;
    s_code  = err_code;
    tick();
    pin_valid = 1'b0;
    pin_ok    = 1'b0;
    #1;
    $display("txn pin ok=%0b error=%0b code=%0d", ok, s_error, s_code);
  endtask

  // Captures EXEC-cycle outputs, then the write-back cycle; returns in MORE.
  task automatic do_op(input logic [1:0] o, input logic [19:0] a);
    op_valid = 1'b1;
    op       = o;
    amount   = a;
    tick();
    op_valid = 1'b0;
    #1;
    s_done  = op_done;
    s_error = error;
    s_code  = err_code;
    tick();
    #1;
    s_we  = balance_we;
    s_bal = balance;
    $display("txn op=%0d amt=%0h done=%0b error=%0b code=%0d we=%0b balance=%0h",
             o, a, s_done, s_error, s_code, s_we, s_bal);
  endtask

  task automatic do_svc(input logic more);
    svc_valid = 1'b1;
    svc_more  = more;
    tick();
    svc_valid = 1'b0;
    #1;
    $display("txn svc more=%0b busy=%0b card_out=%0b", more, busy, card_out);
  endtask

  initial begin
    rst = 1'b0; card_in = 1'b0; acct_balance = '0;
    pin_valid = 1'b0; pin_ok = 1'b0; op_valid = 1'b0; op = 2'b00; amount = '0;
    svc_valid = 1'b0; svc_more = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_balance", balance, 0);
    check("rst_err_code", err_code, 0);
    check("rst_pulses", {balance_we, op_done, error, card_out, card_retained}, 0);
    rst = 1'b1;
    tick();

    // 1: withdraw 300 of 1000, finish
    start_session(20'd1000);
    check("t1_busy", busy, 1);
    check("t1_load", balance, 1000);
    do_pin(1'b1);
    check("t1_pin_err", s_error, 0);
    do_op(2'b00, 20'd300);
    check("t1_done", s_done, 1);
    check("t1_we", s_we, 1);
    check("t1_bal", s_bal, 700);
    do_svc(1'b0);
    check("t1_card_out", card_out, 1);
    tick();
    check("t1_card_out_pulse", card_out, 0);
    check("t1_idle", busy, 0);

    // 2: three wrong PINs -> retained
    start_session(20'd500);
    for (int i = 0; i < 3; i++) begin
      do_pin(1'b0);
      check("t2_err", s_error, 1);
      check("t2_code", s_code, 1);
    end
    check("t2_retained", card_retained, 1);
    check("t2_no_card_out", card_out, 0);
    check("t2_no_we", balance_we, 0);
    check("t2_code_held", err_code, 1);
    tick();
    check("t2_idle", busy, 0);
    check("t2_code_clr", err_code, 0);
    check("t2_ret_pulse", card_retained, 0);

    // 3: funds, limit and zero-amount checks
    start_session(20'd1000);
    do_pin(1'b1);
    do_op(2'b00, 20'd2000);
    check("t3_funds_code", s_code, 2);
    check("t3_funds_done", s_done, 0);
    check("t3_funds_we", s_we, 0);
    check("t3_funds_bal", s_bal, 1000);
    do_svc(1'b1);
    do_op(2'b01, 20'd9000);
    check("t3_dep_done", s_done, 1);
    check("t3_dep_bal", s_bal, 10000);
    do_svc(1'b1);
    do_op(2'b00, 20'd4000);
    check("t3_wd1_bal", s_bal, 6000);
    do_svc(1'b1);
    do_op(2'b00, 20'd1500);
    check("t3_limit_err", s_error, 1);
    check("t3_limit_code", s_code, 3);
    check("t3_limit_bal", s_bal, 6000);
    check("t3_code_hold", err_code, 3);
    do_svc(1'b1);
    do_op(2'b00, 20'd1000);
    check("t3_at_limit_done", s_done, 1);
    check("t3_at_limit_bal", s_bal, 5000);
    do_svc(1'b1);
    do_op(2'b01, 20'd0);
    check("t3_zero_code", s_code, 5);
    check("t3_zero_we", s_we, 0);
    do_svc(1'b0);
    tick();

    // 4: deposit overflow
    start_session(20'hFFFF0);
    do_pin(1'b1);
    do_op(2'b01, 20'h20);
    check("t4_ovf_code", s_code, 4);
    check("t4_ovf_bal", s_bal, 20'hFFFF0);
    do_svc(1'b1);
    do_op(2'b01, 20'hF);
    check("t4_fill_done", s_done, 1);
    check("t4_fill_bal", s_bal, 20'hFFFFF);
    do_svc(1'b1);
    do_op(2'b01, 20'h1);
    check("t4_edge_code", s_code, 4);
    check("t4_edge_bal", s_bal, 20'hFFFFF);
    do_svc(1'b0);
    tick();

    // 5: inactivity timeout in MENU, then op exactly on the timeout cycle
    start_session(20'd100);
    do_pin(1'b1);
    for (int i = 0; i < 7; i++) begin
      check("t5_no_tmo_early", error, 0);
      tick();
    end
    check("t5_tmo_err", error, 1);
    check("t5_tmo_code", err_code, 6);
    tick();
    check("t5_tmo_card_out", card_out, 1);
    check("t5_tmo_code_hold", err_code, 6);
    tick();
    check("t5_tmo_idle", busy, 0);

    start_session(20'd100);
    do_pin(1'b1);
    for (int i = 0; i < 7; i++) tick();
    op_valid = 1'b1;
    op       = 2'b10;
    amount   = '0;
    #1;
    check("t5_race_no_err", error, 0);
    tick();
    op_valid = 1'b0;
    #1;
    check("t5_race_done", op_done, 1);
    tick();
    check("t5_race_in_more", {busy, card_out}, 2'b10);
    check("t5_inq_no_we", balance_we, 0);
    do_svc(1'b0);
    tick();

    // 6: reset during EXEC
    start_session(20'd1000);
    do_pin(1'b1);
    op_valid = 1'b1;
    op       = 2'b00;
    amount   = 20'd100;
    tick();
    op_valid = 1'b0;
    #1;
    check("t6_in_exec", op_done, 1);
    rst = 1'b0;
    #1;
    check("t6_async_done", op_done, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_bal", balance, 0);
    check("t6_async_pulses", {balance_we, error, err_code, card_out, card_retained}, 0);
    tick();
    check("t6_no_we", balance_we, 0);
    rst = 1'b1;
    pin_valid = 1'b1; pin_ok = 1'b1; op_valid = 1'b1; op = 2'b00; amount = 20'd5;
    tick();
    tick();
    check("t6_ignore_busy", busy, 0);
    check("t6_ignore_pulses", {op_done, error, balance_we}, 0);
    pin_valid = 1'b0; pin_ok = 1'b0; op_valid = 1'b0;
    tick();
    start_session(20'd42);
    check("t6_reload", balance, 42);
    do_pin(1'b1);
    op_valid = 1'b1;
    op       = 2'b11;
    tick();
    op_valid = 1'b0;
    #1;
    check("t6_exit_card_out", card_out, 1);
    tick();
    check("t6_exit_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
